// File: rtl/forward_multi_if.sv
// Operand-forwarding bus: consumer operand requests, producer stage results, and resolved operands/status.
interface forward_multi_if #(
   parameter int NSRC = 2,
   parameter int NSTG = 2,
   parameter int AW   = 5,
   parameter int DW   = 32,
   parameter int CW   = 16
);
   logic [NSRC*AW-1:0] src_addr;
   logic [NSRC*DW-1:0] src_rfdata;
   logic [NSTG-1:0]    stg_valid;
   logic [NSTG*AW-1:0] stg_wsel;
   logic [NSTG*DW-1:0] stg_wdat;
   logic [NSTG-1:0]    stg_ready;
   logic               hold;
   logic               flush;
   logic [NSRC*DW-1:0] src_data;
   logic [NSRC-1:0]    src_fwd;
   logic               fwd_stall;
   logic [CW-1:0]      fwd_cnt;
   logic [CW-1:0]      stall_cnt;
   logic               err_timeout;

   modport master (
      output src_addr, src_rfdata, stg_valid, stg_wsel, stg_wdat, stg_ready, hold, flush,
      input  src_data, src_fwd, fwd_stall, fwd_cnt, stall_cnt, err_timeout
   );

   modport slave (
      input  src_addr, src_rfdata, stg_valid, stg_wsel, stg_wdat, stg_ready, hold, flush,
      output src_data, src_fwd, fwd_stall, fwd_cnt, stall_cnt, err_timeout
   );
endinterface

// File: rtl/forward_multi.sv
// Multi-operand forwarding unit: newest-producer bypass, load-use stall, hold-time operand capture,
// saturating hazard counters and a sticky stall watchdog.
module forward_multi #(
   parameter int NSRC      = 2,
   parameter int NSTG      = 2,
   parameter int AW        = 5,
   parameter int DW        = 32,
   parameter int CW        = 16,
   parameter int MAX_STALL = 64
) (
   input logic            i_clk,
   input logic            i_rst,
   forward_multi_if.slave io_bus
);
   logic [AW-1:0]   w_addr    [NSRC];
   logic [DW-1:0]   w_data    [NSRC];
   logic [DW-1:0]   w_hitData [NSRC];
   logic [NSRC-1:0] w_hit;
   logic [NSRC-1:0] w_hitRdy;
   logic [NSRC-1:0] w_fwd;
   logic [NSRC-1:0] w_pend;
   logic            w_stall;

   logic [DW-1:0]   r_capData [NSRC];
   logic [NSRC-1:0] r_capValid;
   logic [CW-1:0]   r_stallRun;
   logic [CW-1:0]   r_fwdCnt;
   logic [CW-1:0]   r_stallCnt;
   logic            r_err;

   // Stages are scanned oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      w_fwd    = '0;
      w_pend   = '0;
      w_hit    = '0;
      w_hitRdy = '0;
      for (int i = 0; i < NSRC; i++) begin
         w_addr[i]    = io_bus.src_addr[i*AW +: AW];
         w_data[i]    = io_bus.src_rfdata[i*DW +: DW];
         w_hitData[i] = '0;
         for (int s = NSTG - 1; s >= 0; s--) begin
            if (io_bus.stg_valid[s] && (io_bus.stg_wsel[s*AW +: AW] == w_addr[i])) begin
               w_hit[i]     = 1'b1;
               w_hitRdy[i]  = io_bus.stg_ready[s];
               w_hitData[i] = io_bus.stg_wdat[s*DW +: DW];
            end
         end
         if (w_addr[i] == '0) begin
            w_data[i] = '0;
         end else if (w_hit[i]) begin
            if (w_hitRdy[i]) begin
               w_data[i] = w_hitData[i];
               w_fwd[i]  = 1'b1;
            end else begin
               w_pend[i] = 1'b1;
            end
         end else if (r_capValid[i]) begin
            w_data[i] = r_capData[i];
            w_fwd[i]  = 1'b1;
         end
      end
   end

   assign w_stall = |w_pend;

   for (genvar g = 0; g < NSRC; g++) begin : g_out
      assign io_bus.src_data[g*DW +: DW] = w_data[g];
   end

   assign io_bus.src_fwd     = w_fwd;
   assign io_bus.fwd_stall   = w_stall;
   assign io_bus.fwd_cnt     = r_fwdCnt;
   assign io_bus.stall_cnt   = r_stallCnt;
   assign io_bus.err_timeout = r_err;

   // Captures only persist across a hold; a pending operand keeps whatever it captured earlier.
   always_ff @(posedge i_clk) begin
      if (i_rst || io_bus.flush || !io_bus.hold) begin
         r_capValid <= '0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if ((w_addr[i] != '0) && !w_pend[i]) begin
               r_capValid[i] <= 1'b1;
               r_capData[i]  <= w_data[i];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || io_bus.flush || !w_stall) begin
         r_stallRun <= '0;
      end else if (r_stallRun != '1) begin
         r_stallRun <= r_stallRun + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err <= 1'b0;
      end else if (w_stall && !io_bus.flush && (r_stallRun == CW'(MAX_STALL - 1))) begin
         r_err <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fwdCnt   <= '0;
         r_stallCnt <= '0;
      end else begin
         if (!io_bus.hold && (|w_fwd) && (r_fwdCnt != '1)) begin
            r_fwdCnt <= r_fwdCnt + 1'b1;
         end
         if (w_stall && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_forward_multi.sv
// Scoreboard bench for forward_multi: directed vectors push expected outputs, a negedge monitor pops and compares.
module tb_forward_multi;
   logic clk;
   logic rst;

   typedef struct {
      string      name;
      bit         ckD0;
      logic [31:0] d0;
      bit         ckD1;
      logic [31:0] d1;
      logic [1:0] fwdMask;
      logic [1:0] fwd;
      bit         stall;
      int         fwdCnt;
      int         stallCnt;
      bit         err;
   } exp_t;

   exp_t expQ [$];
   exp_t monExp;
   int   nAssert = 0;
   int   nFail   = 0;

   forward_multi_if #(.NSRC(2), .NSTG(2), .AW(5), .DW(32), .CW(16)) fwdIf ();

   forward_multi #(
      .NSRC(2), .NSTG(2), .AW(5), .DW(32), .CW(16), .MAX_STALL(4)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .io_bus(fwdIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      nAssert++;
      if (act !== expv) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // The monitor compares one expectation per cycle, halfway between the edges.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monExp = expQ.pop_front();
         if (monExp.ckD0) checkOutput({monExp.name, ".data0"}, fwdIf.src_data[31:0], monExp.d0);
         if (monExp.ckD1) checkOutput({monExp.name, ".data1"}, fwdIf.src_data[63:32], monExp.d1);
         if (monExp.fwdMask[0]) checkOutput({monExp.name, ".fwd0"}, 32'(fwdIf.src_fwd[0]), 32'(monExp.fwd[0]));
         if (monExp.fwdMask[1]) checkOutput({monExp.name, ".fwd1"}, 32'(fwdIf.src_fwd[1]), 32'(monExp.fwd[1]));
         checkOutput({monExp.name, ".stall"}, 32'(fwdIf.fwd_stall), 32'(monExp.stall));
         checkOutput({monExp.name, ".fwdCnt"}, 32'(fwdIf.fwd_cnt), 32'(monExp.fwdCnt));
         checkOutput({monExp.name, ".stallCnt"}, 32'(fwdIf.stall_cnt), 32'(monExp.stallCnt));
         checkOutput({monExp.name, ".err"}, 32'(fwdIf.err_timeout), 32'(monExp.err));
      end
   end

   function automatic exp_t mk(input string n, input bit ck0, input logic [31:0] d0,
                               input bit ck1, input logic [31:0] d1,
                               input logic [1:0] fm, input logic [1:0] f, input bit st,
                               input int fc, input int sc, input bit er);
      exp_t e;
      e.name = n; e.ckD0 = ck0; e.d0 = d0; e.ckD1 = ck1; e.d1 = d1;
      e.fwdMask = fm; e.fwd = f; e.stall = st; e.fwdCnt = fc; e.stallCnt = sc; e.err = er;
      return e;
   endfunction

   task automatic setStage(input int s, input bit v, input logic [4:0] w, input logic [31:0] d, input bit r);
      fwdIf.stg_valid[s]        = v;
      fwdIf.stg_wsel[s*5 +: 5]  = w;
      fwdIf.stg_wdat[s*32 +: 32] = d;
      fwdIf.stg_ready[s]        = r;
   endtask

   task automatic setSrc(input int i, input logic [4:0] a, input logic [31:0] rf);
      fwdIf.src_addr[i*5 +: 5]     = a;
      fwdIf.src_rfdata[i*32 +: 32] = rf;
   endtask

   task automatic applyStimulus(input exp_t e);
      expQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      fwdIf.src_addr = '0; fwdIf.src_rfdata = '0;
      fwdIf.stg_valid = '0; fwdIf.stg_wsel = '0; fwdIf.stg_wdat = '0; fwdIf.stg_ready = '0;
      fwdIf.hold = 1'b0; fwdIf.flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      setSrc(0, 5'd4, 32'hA0); setSrc(1, 5'd6, 32'hB0);
      applyStimulus(mk("reset", 1, 32'hA0, 1, 32'hB0, 2'b11, 2'b00, 0, 0, 0, 0));

      // Youngest stage wins; same register on both operands resolves identically.
      setStage(0, 1, 5'd3, 32'h11, 1); setStage(1, 1, 5'd3, 32'h22, 1);
      setSrc(0, 5'd3, 32'h0); setSrc(1, 5'd3, 32'h0);
      applyStimulus(mk("dupWsel", 1, 32'h11, 1, 32'h11, 2'b11, 2'b11, 0, 0, 0, 0));

      setStage(0, 0, 5'd0, 32'h0, 0); setSrc(1, 5'd4, 32'hB1);
      applyStimulus(mk("olderStage", 1, 32'h22, 1, 32'hB1, 2'b11, 2'b01, 0, 1, 0, 0));

      setStage(0, 1, 5'd0, 32'hFF, 1); setStage(1, 0, 5'd0, 32'h0, 0);
      setSrc(0, 5'd9, 32'h99); setSrc(1, 5'd0, 32'h77);
      applyStimulus(mk("addrZero", 1, 32'h99, 1, 32'h0, 2'b11, 2'b00, 0, 2, 0, 0));

      setStage(0, 1, 5'd5, 32'hDEAD, 0); setStage(1, 1, 5'd8, 32'h88, 1);
      setSrc(0, 5'd5, 32'h0); setSrc(1, 5'd8, 32'h0);
      applyStimulus(mk("loadUse", 0, 32'h0, 1, 32'h88, 2'b10, 2'b10, 1, 2, 0, 0));

      setStage(0, 1, 5'd5, 32'hAB, 1);
      applyStimulus(mk("loadDone", 1, 32'hAB, 1, 32'h88, 2'b11, 2'b11, 0, 3, 1, 0));

      fwdIf.hold = 1'b1;
      setStage(0, 0, 5'd0, 32'h0, 0); setStage(1, 1, 5'd7, 32'h55, 1);
      setSrc(0, 5'd7, 32'h0); setSrc(1, 5'd8, 32'h88);
      applyStimulus(mk("holdCap", 1, 32'h55, 1, 32'h88, 2'b11, 2'b01, 0, 4, 1, 0));

      setStage(1, 0, 5'd0, 32'h0, 0); setSrc(1, 5'd8, 32'h99);
      applyStimulus(mk("holdUseCap", 1, 32'h55, 1, 32'h88, 2'b11, 2'b11, 0, 4, 1, 0));

      fwdIf.hold = 1'b0;
      applyStimulus(mk("holdDrop", 1, 32'h55, 1, 32'h88, 2'b11, 2'b11, 0, 4, 1, 0));

      setSrc(0, 5'd7, 32'h3C);
      applyStimulus(mk("afterHold", 1, 32'h3C, 1, 32'h99, 2'b11, 2'b00, 0, 5, 1, 0));

      fwdIf.hold = 1'b1;
      setStage(0, 1, 5'd10, 32'h66, 1);
      setSrc(0, 5'd10, 32'h01); setSrc(1, 5'd0, 32'h0);
      applyStimulus(mk("cap2", 1, 32'h66, 1, 32'h0, 2'b11, 2'b01, 0, 5, 1, 0));

      fwdIf.flush = 1'b1;
      setStage(0, 0, 5'd0, 32'h0, 0);
      applyStimulus(mk("flushHold", 1, 32'h66, 1, 32'h0, 2'b11, 2'b01, 0, 5, 1, 0));

      fwdIf.flush = 1'b0; fwdIf.hold = 1'b0;
      applyStimulus(mk("afterFlush", 1, 32'h01, 1, 32'h0, 2'b11, 2'b00, 0, 5, 1, 0));

      // Four consecutive stall cycles trip the watchdog at the fourth edge.
      setStage(0, 1, 5'd12, 32'h0, 0); setSrc(0, 5'd12, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(mk($sformatf("stall%0d", k), 0, 32'h0, 1, 32'h0, 2'b10, 2'b00, 1, 5, k, 0));
      end

      setStage(0, 1, 5'd12, 32'h12, 1);
      applyStimulus(mk("stallEnd", 1, 32'h12, 1, 32'h0, 2'b11, 2'b01, 0, 5, 5, 1));

      setStage(0, 0, 5'd0, 32'h0, 0); setSrc(0, 5'd4, 32'hA0);
      applyStimulus(mk("errSticky", 1, 32'hA0, 1, 32'h0, 2'b11, 2'b00, 0, 6, 5, 1));

      fwdIf.hold = 1'b1;
      setStage(0, 1, 5'd13, 32'h44, 1); setSrc(0, 5'd13, 32'h05);
      applyStimulus(mk("capPreRst", 1, 32'h44, 1, 32'h0, 2'b11, 2'b01, 0, 6, 5, 1));

      rst = 1'b1;
      setStage(0, 0, 5'd0, 32'h0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0; fwdIf.hold = 1'b0;
      applyStimulus(mk("rstMidHold", 1, 32'h05, 1, 32'h0, 2'b11, 2'b00, 0, 0, 0, 0));

      repeat (3) @(posedge clk);
      nAssert++;
      if (expQ.size() != 0) begin
         nFail++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end
endmodule
